// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator: turns RV32I load/store requests into word-wide
// memory handshakes; sub-word stores are done as read-modify-write.
module load_store_unit #(
  parameter int TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        PIPE_READ,
  input  logic        PIPE_WRITE,
  input  logic [2:0]  PIPE_FUNCT3,
  input  logic [31:0] PIPE_ADDRESS,
  input  logic [31:0] PIPE_WDATA,
  output logic        STALL,
  output logic [31:0] LOAD_DATA,
  output logic        LOAD_VALID,
  output logic        FAULT,
  output logic [1:0]  FAULT_CAUSE,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [2:0]  FUNCT3,
  output logic [31:0] MEM_ADDRESS,
  output logic [31:0] DATA_OUT,
  input  logic [31:0] DATA_IN,
  input  logic        BUSYWAIT
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, RD, MERGE, WR, DONE} state_t;

  state_t        state_q, state_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic          load_valid_q, load_valid_d;
  logic          fault_q, fault_d;
  logic          seen_busy_q, seen_busy_d;
  logic          wr_q, wr_d;
  logic [1:0]    fault_cause_q, fault_cause_d;
  logic [1:0]    off_q, off_d;
  logic [2:0]    f3_q, f3_d;
  logic [31:0]   load_data_q, load_data_d;
  logic [31:0]   data_out_q, data_out_d;
  logic [31:0]   mem_address_q, mem_address_d;
  logic [31:0]   merge_q, merge_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        req, illegal, misalign, is_sw, hs_done, timed_out;
  logic [4:0]  sh;
  logic [15:0] lane;
  logic [31:0] ext_data, mask, merged;

  always_comb begin
    req = PIPE_READ | PIPE_WRITE;
    if (PIPE_READ && PIPE_WRITE)
      illegal = 1'b1;
    else if (PIPE_READ)
      illegal = !(PIPE_FUNCT3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    else
      illegal = PIPE_FUNCT3[2] || (PIPE_FUNCT3[1:0] == 2'b11);
    misalign = ((PIPE_FUNCT3[1:0] == 2'b01) && PIPE_ADDRESS[0]) ||
               ((PIPE_FUNCT3[1:0] == 2'b10) && (PIPE_ADDRESS[1:0] != 2'b00));
    is_sw     = PIPE_WRITE && (PIPE_FUNCT3[1:0] == 2'b10);
    // A handshake only counts once memory has shown it is busy with it.
    hs_done   = seen_busy_q && !BUSYWAIT;
    timed_out = (cnt_q == CNT_LAST);

    sh   = {off_q, 3'b000};
    lane = 16'(DATA_IN >> sh);
    case (f3_q)
      3'b000:  ext_data = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ext_data = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ext_data = {24'd0, lane[7:0]};
      3'b101:  ext_data = {16'd0, lane[15:0]};
      default: ext_data = DATA_IN;
    endcase
    mask   = (f3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
    merged = (merge_q & ~mask) | ((PIPE_WDATA << sh) & mask);
  end

  always_comb begin
    state_d       = state_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    load_valid_d  = 1'b0;
    fault_d       = 1'b0;
    fault_cause_d = fault_cause_q;
    seen_busy_d   = seen_busy_q;
    wr_d          = wr_q;
    off_d         = off_q;
    f3_d          = f3_q;
    load_data_d   = load_data_q;
    data_out_d    = data_out_q;
    mem_address_d = mem_address_q;
    merge_d       = merge_q;
    cnt_d         = cnt_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          if (illegal) begin
            fault_d       = 1'b1;
            fault_cause_d = 2'b10;
            state_d       = DONE;
          end else if (misalign) begin
            fault_d       = 1'b1;
            fault_cause_d = 2'b01;
            state_d       = DONE;
          end else begin
            f3_d          = PIPE_FUNCT3;
            off_d         = PIPE_ADDRESS[1:0];
            wr_d          = PIPE_WRITE;
            mem_address_d = {PIPE_ADDRESS[31:2], 2'b00};
            seen_busy_d   = 1'b0;
            cnt_d         = '0;
            if (is_sw) begin
              data_out_d  = PIPE_WDATA;
              mem_write_d = 1'b1;
              state_d     = WR;
            end else begin
              mem_read_d  = 1'b1;
              state_d     = RD;
            end
          end
        end
      end
      RD: begin
        seen_busy_d = seen_busy_q | BUSYWAIT;
        cnt_d       = cnt_q + 1'b1;
        if (hs_done) begin
          mem_read_d = 1'b0;
          cnt_d      = '0;
          if (wr_q) begin
            merge_d = DATA_IN;
            state_d = MERGE;
          end else begin
            load_data_d  = ext_data;
            load_valid_d = 1'b1;
            state_d      = DONE;
          end
        end else if (timed_out) begin
          mem_read_d    = 1'b0;
          cnt_d         = '0;
          fault_d       = 1'b1;
          fault_cause_d = 2'b11;
          state_d       = DONE;
        end
      end
      MERGE: begin
        data_out_d  = merged;
        mem_write_d = 1'b1;
        seen_busy_d = 1'b0;
        cnt_d       = '0;
        state_d     = WR;
      end
      WR: begin
        seen_busy_d = seen_busy_q | BUSYWAIT;
        cnt_d       = cnt_q + 1'b1;
        if (hs_done) begin
          mem_write_d = 1'b0;
          cnt_d       = '0;
          state_d     = DONE;
        end else if (timed_out) begin
          mem_write_d   = 1'b0;
          cnt_d         = '0;
          fault_d       = 1'b1;
          fault_cause_d = 2'b11;
          state_d       = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q       <= IDLE;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      load_valid_q  <= 1'b0;
      fault_q       <= 1'b0;
      fault_cause_q <= 2'b00;
      seen_busy_q   <= 1'b0;
      wr_q          <= 1'b0;
      off_q         <= 2'b00;
      f3_q          <= 3'b000;
      load_data_q   <= '0;
      data_out_q    <= '0;
      mem_address_q <= '0;
      merge_q       <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      load_valid_q  <= load_valid_d;
      fault_q       <= fault_d;
      fault_cause_q <= fault_cause_d;
      seen_busy_q   <= seen_busy_d;
      wr_q          <= wr_d;
      off_q         <= off_d;
      f3_q          <= f3_d;
      load_data_q   <= load_data_d;
      data_out_q    <= data_out_d;
      mem_address_q <= mem_address_d;
      merge_q       <= merge_d;
      cnt_q         <= cnt_d;
    end
  end

  assign STALL       = ((state_q == IDLE) && req) ||
                       (state_q == RD) || (state_q == MERGE) || (state_q == WR);
  assign LOAD_DATA   = load_data_q;
  assign LOAD_VALID  = load_valid_q;
  assign FAULT       = fault_q;
  assign FAULT_CAUSE = fault_cause_q;
  assign MEM_READ    = mem_read_q;
  assign MEM_WRITE   = mem_write_q;
  assign FUNCT3      = 3'b010;
  assign MEM_ADDRESS = mem_address_q;
  assign DATA_OUT    = data_out_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: a word memory with programmable busy
// length, plus an arithmetic reference model of loads, stores and faults.
module tb_load_store_unit;
  localparam int TO = 8;

  logic        CLK = 1'b0, RESET = 1'b0;
  logic        PIPE_READ = 1'b0, PIPE_WRITE = 1'b0;
  logic [2:0]  PIPE_FUNCT3 = '0;
  logic [31:0] PIPE_ADDRESS = '0, PIPE_WDATA = '0;
  logic [31:0] DATA_IN = '0;
  logic        BUSYWAIT = 1'b0;
  logic        STALL, LOAD_VALID, FAULT, MEM_READ, MEM_WRITE;
  logic [31:0] LOAD_DATA, MEM_ADDRESS, DATA_OUT;
  logic [1:0]  FAULT_CAUSE;
  logic [2:0]  FUNCT3;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET(RESET), .PIPE_READ(PIPE_READ), .PIPE_WRITE(PIPE_WRITE),
    .PIPE_FUNCT3(PIPE_FUNCT3), .PIPE_ADDRESS(PIPE_ADDRESS), .PIPE_WDATA(PIPE_WDATA),
    .STALL(STALL), .LOAD_DATA(LOAD_DATA), .LOAD_VALID(LOAD_VALID), .FAULT(FAULT),
    .FAULT_CAUSE(FAULT_CAUSE), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .FUNCT3(FUNCT3), .MEM_ADDRESS(MEM_ADDRESS), .DATA_OUT(DATA_OUT),
    .DATA_IN(DATA_IN), .BUSYWAIT(BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory model: BUSYWAIT high for bw_cfg sampled edges per access, writes
  // commit when busy drops. bw_cfg == 0 means memory never responds.
  logic [31:0] mem_arr [256];
  bit          mem_ready = 0, active = 0, committed = 0, prev_rd = 0;
  int          bw_cfg = 1, left = 0;
  int          rd_cnt = 0, wr_cnt = 0, overlap = 0, gap_viol = 0, bad_f3 = 0;
  logic [31:0] last_wa = '0, last_wd = '0;

  always @(negedge CLK) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem_arr[i] = init_word(i);
      mem_ready = 1;
    end
    if (MEM_READ && MEM_WRITE) overlap++;
    if (MEM_WRITE && prev_rd) gap_viol++;
    if ((MEM_READ || MEM_WRITE) && FUNCT3 != 3'b010) bad_f3++;
    if (!(MEM_READ || MEM_WRITE)) begin
      active   = 0;
      BUSYWAIT = 1'b0;
    end else if (!active) begin
      active    = 1;
      committed = 0;
      left      = bw_cfg;
      if (MEM_READ) rd_cnt++; else wr_cnt++;
      BUSYWAIT  = (left > 0);
    end else begin
      if (left > 0) left--;
      BUSYWAIT = (left > 0);
      if (MEM_WRITE && left == 0 && bw_cfg > 0 && !committed) begin
        mem_arr[MEM_ADDRESS[9:2]] = DATA_OUT;
        committed = 1;
        last_wa   = MEM_ADDRESS;
        last_wd   = DATA_OUT;
      end
    end
    prev_rd = MEM_READ;
    DATA_IN = mem_arr[MEM_ADDRESS[9:2]];
  end

  logic [31:0] ref_mem [256];
  logic [1:0]  last_cause = 2'b00;
  logic [31:0] last_ld;

  // Called and returns at 1 time unit after a posedge, so requests go back-to-back.
  task automatic run_op(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int bw, input string tag);
    int idx, sz, sh, exp_stall, stalls, r0, w0;
    bit legal, mis, acc, sw, tmo, exp_fault, fin, lv, flt, mreq;
    logic [1:0]  exp_cause;
    logic [31:0] w, b, h, exp_ld, new_w, ld;
    idx = int'(addr[9:2]);
    w   = ref_mem[idx];
    sh  = 8 * int'(addr[1:0]);
    b   = (w >> sh) & 32'hFF;
    h   = (w >> sh) & 32'hFFFF;
    if (rd && wr)  legal = 0;
    else if (rd)   legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    else           legal = (f3 inside {3'd0, 3'd1, 3'd2});
    sz  = 1 << f3[1:0];
    mis = legal && (int'(addr[1:0]) % sz != 0);
    acc = legal && !mis;
    sw  = wr && f3 == 3'd2;
    tmo = acc && bw == 0;
    exp_fault = !acc || tmo;
    exp_cause = !legal ? 2'b10 : mis ? 2'b01 : 2'b11;
    case (f3)
      3'd0:    exp_ld = (b >= 128) ? b - 32'd256 : b;
      3'd1:    exp_ld = (h >= 32768) ? h - 32'd65536 : h;
      3'd4:    exp_ld = b;
      3'd5:    exp_ld = h;
      default: exp_ld = w;
    endcase
    case (f3)
      3'd0:    new_w = w - (b << sh) + ((wd & 32'hFF) << sh);
      3'd1:    new_w = w - (h << sh) + ((wd & 32'hFFFF) << sh);
      default: new_w = wd;
    endcase
    if (!acc)          exp_stall = 1;
    else if (tmo)      exp_stall = 1 + TO;
    else if (rd || sw) exp_stall = bw + 2;
    else               exp_stall = -1;

    r0 = rd_cnt; w0 = wr_cnt;
    PIPE_READ = rd; PIPE_WRITE = wr; PIPE_FUNCT3 = f3;
    PIPE_ADDRESS = addr; PIPE_WDATA = wd; bw_cfg = bw;
    stalls = 0; fin = 0; lv = 0; flt = 0; mreq = 0; ld = '0;
    for (int c = 0; c < 200 && !fin; c++) begin
      #1;
      if (STALL) begin
        stalls++;
        @(posedge CLK); #1;
      end else begin
        lv = LOAD_VALID; flt = FAULT; ld = LOAD_DATA;
        mreq = MEM_READ | MEM_WRITE;
        fin = 1;
      end
    end
    if (!fin) chk({tag, "_bound"}, 32'd0, 32'd1);
    @(posedge CLK); #1;
    PIPE_READ = 0; PIPE_WRITE = 0;

    if (exp_fault) last_cause = exp_cause;
    if (acc && wr && !tmo) ref_mem[idx] = new_w;
    last_ld = ld;
    chk({tag, "_valid"}, 32'(lv), 32'(acc && rd && !tmo));
    chk({tag, "_fault"}, 32'(flt), 32'(exp_fault));
    chk({tag, "_cause"}, 32'(FAULT_CAUSE), 32'(last_cause));
    chk({tag, "_reqdone"}, 32'(mreq), 32'd0);
    if (acc && rd && !tmo) chk({tag, "_data"}, ld, exp_ld);
    if (exp_stall >= 0) chk({tag, "_stall"}, 32'(stalls), 32'(exp_stall));
    chk({tag, "_reads"}, 32'(rd_cnt - r0), 32'(acc && !sw));
    chk({tag, "_writes"}, 32'(wr_cnt - w0), 32'(acc && wr && (sw || !tmo)));
    chk({tag, "_mem"}, mem_arr[idx], ref_mem[idx]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [2:0] lf [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    int w0, op, kind, off, sz, bw;
    bit rd, wr;
    logic [2:0] f3;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

    RESET = 0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_stall", 32'(STALL), 0);
    chk("rst_rd", 32'(MEM_READ), 0);
    chk("rst_wr", 32'(MEM_WRITE), 0);
    chk("rst_lv", 32'(LOAD_VALID), 0);
    chk("rst_fault", 32'(FAULT), 0);
    chk("rst_cause", 32'(FAULT_CAUSE), 0);
    chk("rst_ldata", LOAD_DATA, 0);
    chk("rst_dout", DATA_OUT, 0);
    chk("rst_addr", MEM_ADDRESS, 0);
    chk("funct3", 32'(FUNCT3), 32'h2);
    RESET = 1;

    run_op(0, 1, 3'd2, 32'h100, 32'h80FF7F01, 1, "sw_init");
    run_op(1, 0, 3'd0, 32'h102, 32'h0, 1, "lb");
    chk("lb_const", last_ld, 32'hFFFFFFFF);
    run_op(1, 0, 3'd4, 32'h102, 32'h0, 3, "lbu");
    chk("lbu_const", last_ld, 32'h000000FF);
    run_op(1, 0, 3'd1, 32'h102, 32'h0, 3, "lh");
    chk("lh_const", last_ld, 32'hFFFF80FF);

    run_op(0, 1, 3'd2, 32'h100, 32'h11223344, 2, "sw_prep");
    run_op(0, 1, 3'd0, 32'h101, 32'h000000AB, 2, "sb");
    chk("sb_word", mem_arr[32'h100 >> 2], 32'h1122AB44);
    run_op(0, 1, 3'd2, 32'h200, 32'hDEADBEEF, 2, "sw");
    chk("sw_addr", last_wa, 32'h200);
    chk("sw_data", last_wd, 32'hDEADBEEF);

    run_op(1, 0, 3'd2, 32'h203, 32'h0, 1, "lw_mis");
    run_op(1, 1, 3'd2, 32'h204, 32'h0, 1, "rdwr");
    run_op(1, 0, 3'd2, 32'h104, 32'h0, 0, "lw_tmo");
    run_op(0, 1, 3'd1, 32'h106, 32'h0000BEEF, 0, "sh_tmo");

    run_op(1, 0, 3'd2, 32'h108, 32'h0, 2, "b2b_lw");
    run_op(0, 1, 3'd1, 32'h10A, 32'h00005A5A, 1, "b2b_sh");

    // Reset in the middle of an RMW read: no write may follow.
    w0 = wr_cnt;
    PIPE_WRITE = 1; PIPE_FUNCT3 = 3'd0; PIPE_ADDRESS = 32'h10C; PIPE_WDATA = 32'h55;
    bw_cfg = 5;
    repeat (2) begin @(posedge CLK); #1; end
    chk("mid_rd", 32'(MEM_READ), 1);
    RESET = 0; PIPE_WRITE = 0;
    @(posedge CLK); #1;
    chk("mrst_stall", 32'(STALL), 0);
    chk("mrst_rd", 32'(MEM_READ), 0);
    chk("mrst_wr", 32'(MEM_WRITE), 0);
    chk("mrst_cause", 32'(FAULT_CAUSE), 0);
    chk("mrst_ldata", LOAD_DATA, 0);
    chk("mrst_dout", DATA_OUT, 0);
    chk("mrst_addr", MEM_ADDRESS, 0);
    chk("mrst_lv_flt", 32'({LOAD_VALID, FAULT}), 0);
    last_cause = 2'b00;
    RESET = 1;
    repeat (3) begin @(posedge CLK); #1; end
    chk("mrst_nowrite", 32'(wr_cnt - w0), 0);

    for (int n = 0; n < 80; n++) begin
      op   = $urandom_range(0, 7);
      rd   = (op < 5);
      wr   = !rd;
      f3   = rd ? lf[op] : 3'(op - 5);
      sz   = 1 << f3[1:0];
      off  = ($urandom_range(0, 3) / sz) * sz;
      kind = $urandom_range(0, 19);
      if (kind == 0) begin rd = 1; wr = 1; end
      else if (kind == 1) f3 = rd ? 3'd3 + 3'($urandom_range(0, 1)) * 3'd3 : 3'($urandom_range(3, 7));
      else if (kind == 2 && sz > 1) off = (off + 1) % 4;
      bw = (kind == 3) ? 0 : $urandom_range(1, 3);
      run_op(rd, wr, f3, 32'h100 + 32'($urandom_range(0, 15)) * 4 + 32'(off),
             $urandom, bw, "rand");
      if ($urandom_range(0, 3) == 0) begin @(posedge CLK); #1; end
    end

    chk("no_overlap", 32'(overlap), 0);
    chk("rmw_gap", 32'(gap_viol), 0);
    chk("bus_funct3", 32'(bad_f3), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
